apb_burst_sequencer: RTL and testbench
======================================

# apb_burst_sequencer

Command-driven APB transfer sequencer placed directly upstream of `apb_bridge`. It accepts one burst command at a time: direction, data size, start address and length. It then drives the bridge's master-side transfer inputs (`trnsfr`, `wr`, `dsel`, `address`, `data_in`) beat by beat, holding the bus stable until the bridge reports `ready`. Write data arrives through a valid/ready stream with a one-entry prefetch buffer; read data leaves as a one-cycle valid pulse per beat.

## Interface
- `ADDR_WIDTH`, 32, address width; matches the bridge.
- `DATA_WIDTH`, 32, data width; matches the bridge.
- `LEN_WIDTH`, 8, burst length field width; beats = `cmd_len` + 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_dsel`  in  2  data select: FULLWORD = 0, HALFWORD = 1, BYTE = 2.
- `cmd_addr`  in  `ADDR_WIDTH`  start address.
- `cmd_len`  in  `LEN_WIDTH`  beats minus one.
- `wdata_valid` / `wdata_ready`  in / out  1  write data handshake.
- `wdata`  in  `DATA_WIDTH`  write beat data, passed to `data_in` unmodified.
- `rdata_valid`  out  1  one-cycle pulse per completed read beat; no backpressure.
- `rdata`  out  `DATA_WIDTH`  captured `data_out`.
- `done`  out  1  one-cycle pulse when the burst ends.
- `err`  out  1  sticky slave error for the current burst; valid while `done` is high.
- `trnsfr`, `wr`  out  1  bridge transfer request and direction.
- `dsel`  out  2  bridge data select.
- `address`  out  `ADDR_WIDTH`  bridge address.
- `data_in`  out  `DATA_WIDTH`  bridge write data.
- `data_out`  in  `DATA_WIDTH`  bridge read data.
- `ready`  in  1  bridge beat completion.
- `slverr`  in  1  bridge error for the current beat; qualified by `ready`.

## Operation
- States: IDLE, LOAD, XFER, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept, register `wr`, `dsel`, `address` = `cmd_addr`, `beats_left` = `cmd_len`, and clear `err`.
  - Next state: XFER for a read; LOAD for a write.
- **LOAD**
  - `trnsfr` = 0 and `wdata_ready` = 1.
  - On `wdata_valid`, register `data_in` and go to XFER.
- **XFER**
  - `trnsfr` = 1. `address`, `wr`, `dsel` and `data_in` stay stable until `ready`.
  - For writes, `wdata_ready` = 1 while the prefetch buffer is empty, so the next beat is buffered during the current one.
  - On `ready`:
    - Set `err` |= `slverr`.
    - For a read, capture `data_out` into `rdata` and assert `rdata_valid` the next cycle.
    - If `beats_left` == 0, go to DONE.
    - Otherwise set `address` += 1 (wraps modulo 2^`ADDR_WIDTH`) and `beats_left` -= 1.
    - A read stays in XFER.
    - A write with the prefetch buffer full moves the buffer into `data_in` and stays in XFER. With the buffer empty, it goes to LOAD and `trnsfr` drops.
- **DONE**
  - `done` = 1 for one cycle, `trnsfr` = 0, then return to IDLE.
  - Any prefetch contents remaining are discarded.
- A new command is accepted no earlier than the cycle after `done`.
- The address increments by 1 per beat regardless of `dsel`, because the address is a beat index.
- `dsel` values other than 0/1/2 are passed through unchanged; the bridge handles them.

## Timing
- Reset value of every output is 0, except `cmd_ready` = 1, since the block resets into IDLE.
- Reset is asynchronous: asserting `rst_n` mid-burst drops `trnsfr` immediately and abandons the burst with no `done`.
- Read latency:
  - Command accepted at edge 0; `trnsfr` high from cycle 1.
  - `ready` sampled at edge k; `rdata_valid` high in cycle k+1.
- Write with data present: a command with `wdata_valid` already high gives `trnsfr` high two cycles after accept.
- Back-to-back beats keep `trnsfr` continuously high; the new address/data appear in the cycle after `ready`.
- `done` is asserted in the cycle after the final `ready` and coincides with the last `rdata_valid`.
- `ready` outside XFER is ignored.

## Configuration
- `APB_SEQ_ERR_ABORT_EN`
  - Defined: `slverr` on any beat goes to DONE after that beat. Remaining beats are not issued, `err` = 1, and unread write data stays upstream.
  - Undefined: all beats are issued, and `err` reports the OR of all beat errors.

## Structure
- Shared package `apb_seq_pkg` holds:
  - the `dsel_type` enum (FULLWORD, HALFWORD, BYTE; 2 bits);
  - the sequencer state enum;
  - the beat-length type.
- No sub-module. The prefetch buffer, beat counter and address generator are small registers inside this module.

## Test plan
- **Single full-word write:** write, FULLWORD, addr 0xF0, len 0, wdata 0x000A3210 -> one `trnsfr` beat with `address` 0xF0 and `data_in` 0x000A3210; `done` the cycle after `ready`; `err` = 0.
- **Burst write, continuous data:** write, len 7, addr 0xB0, wdata 0xC0D942F0+i with `wdata_valid` always high -> `trnsfr` high across all 8 beats, addresses 0xB0..0xB7, one `done`.
- **Burst read:** read, len 7, addr 0xB0 after the previous burst -> 8 `rdata_valid` pulses carrying 0xC0D942F0..0xC0D942F7 in order.
- **Write data stall:** len 3 write with `wdata_valid` withheld for 4 cycles after beat 1 -> `trnsfr` low during the gap, then resumes at addr+2 with the correct data.
- **Slave error:** `slverr` on beat 1 of a len 3 burst at 0x100 -> with `APB_SEQ_ERR_ABORT_EN`, `done` follows beat 1 with `err` = 1; without it, all 4 beats are issued and `err` = 1.
- **Reset mid-burst:** `rst_n` low during beat 3 of 8 -> all outputs 0 immediately; after release, `cmd_ready` = 1 and a new len 0 read completes normally.

Source files
------------

// File: rtl/apb_seq_pkg.sv
// Shared types for the APB burst sequencer: bridge data-select encoding,
// sequencer states and the burst length field.
package apb_seq_pkg;

    localparam int BEAT_LEN_W = 8;

    typedef enum logic [1:0] {
        FULLWORD = 2'd0,
        HALFWORD = 2'd1,
        BYTE     = 2'd2
    } dsel_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    typedef logic [BEAT_LEN_W-1:0] beat_len_t;

endpackage

// File: rtl/apb_burst_sequencer.sv
// Command-driven burst sequencer feeding the master side of apb_bridge.
// Optional build macro APB_SEQ_ERR_ABORT_EN: end the burst after the first slverr beat.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | write beat waiting for stream data, bus idle
// XFER  | beat on the bus, held until bridge ready
// DONE  | one-cycle done pulse, prefetch discarded
module apb_burst_sequencer
    import apb_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = BEAT_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [1:0]            cmd_dsel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  trnsfr,
    output logic                  wr,
    output logic [1:0]            dsel,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready,
    input  logic                  slverr
);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [DATA_WIDTH-1:0] pf_data;
    logic                  pf_full;
    logic                  accept;
    logic                  wd_fire;
    logic                  abort_err;
    logic                  last_beat;

`ifdef APB_SEQ_ERR_ABORT_EN
    assign abort_err = slverr;
`else
    assign abort_err = 1'b0;
`endif

    assign accept    = cmd_valid & cmd_ready;
    assign wd_fire   = wdata_valid & wdata_ready;
    assign last_beat = (beats_left == '0) | abort_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        trnsfr      = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = cmd_wr ? LOAD : XFER;
            end
            LOAD: begin
                wdata_ready = 1'b1;
                if (wdata_valid) state_nxt = XFER;
            end
            XFER: begin
                trnsfr      = 1'b1;
                wdata_ready = wr & ~pf_full;
                if (ready) begin
                    if (last_beat)
                        state_nxt = DONE;
                    // a word arriving with the completing beat goes straight to data_in
                    else if (wr && !pf_full && !wdata_valid)
                        state_nxt = LOAD;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr          <= 1'b0;
            dsel        <= 2'd0;
            address     <= '0;
            data_in     <= '0;
            beats_left  <= '0;
            pf_data     <= '0;
            pf_full     <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr         <= cmd_wr;
                        dsel       <= cmd_dsel;
                        address    <= cmd_addr;
                        beats_left <= cmd_len;
                        err        <= 1'b0;
                        pf_full    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wdata_valid) data_in <= wdata;
                end
                XFER: begin
                    if (ready) begin
                        err <= err | slverr;
                        if (!wr) begin
                            rdata       <= data_out;
                            rdata_valid <= 1'b1;
                        end
                        if (!last_beat) begin
                            address    <= address + ADDR_WIDTH'(1);
                            beats_left <= beats_left - LEN_WIDTH'(1);
                            if (wr && pf_full) begin
                                data_in <= pf_data;
                                pf_full <= 1'b0;
                            end else if (wd_fire) begin
                                data_in <= wdata;
                            end
                        end else if (wd_fire) begin
                            pf_data <= wdata;
                            pf_full <= 1'b1;
                        end
                    end else if (wd_fire) begin
                        pf_data <= wdata;
                        pf_full <= 1'b1;
                    end
                end
                DONE: begin
                    pf_full <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_burst_sequencer.sv
// Self-checking bench for apb_burst_sequencer: directed scenarios plus randomized
// bursts, checked against a beat-list/memory reference model.
module tb_apb_burst_sequencer;
    import apb_seq_pkg::*;

`ifdef APB_SEQ_ERR_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [1:0]  cmd_dsel;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done, err, trnsfr, wr;
    logic [1:0]  dsel;
    logic [31:0] address, data_in, data_out;
    logic        ready, slverr;

    apb_burst_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_dsel(cmd_dsel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
        .trnsfr(trnsfr), .wr(wr), .dsel(dsel), .address(address),
        .data_in(data_in), .data_out(data_out), .ready(ready), .slverr(slverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // slave / stream / monitor state
    int          cyc = 0;
    logic [31:0] smem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] wwords [64];
    int          widx = 0;
    bit          fire_pending = 0;
    bit          wen = 0;
    int          stall_at = -1, stall_left = 0;
    int          max_wait = 0, wait_cnt = 0;
    bit          latched = 0;
    logic [31:0] l_addr, l_data;
    logic        l_wr;
    logic [1:0]  l_dsel;
    int          beat_idx = 0, err_beat = -1;
    logic [31:0] b_addr[$], b_data[$], rq[$];
    logic        b_wr[$];
    logic [1:0]  b_dsel[$];
    int          done_cnt = 0;
    logic        done_err = 0, done_rv = 0;
    int          acc_cyc = 0, first_tr_cyc = 0, last_rdy_cyc = 0, done_cyc = 0;
    bit          seen_tr = 0;
    int          gap_cnt = 0, unstable = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        ready = 0; slverr = 0; data_out = 0; wdata_valid = 0; wdata = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                ready = 0; slverr = 0; latched = 0; wdata_valid = 0; fire_pending = 0;
                continue;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rdata_valid) rq.push_back(rdata);
            if (done) begin
                done_cnt++; done_err = err; done_rv = rdata_valid; done_cyc = cyc;
            end
            if (seen_tr && !trnsfr && !done && done_cnt == 0) gap_cnt++;
            if (fire_pending) widx++;
            if (wen && widx == stall_at && stall_left > 0) begin
                wdata_valid = 0;
                stall_left--;
            end else begin
                wdata_valid = wen;
            end
            wdata = wwords[widx % 64];
            fire_pending = wdata_valid && wdata_ready;
            ready = 0; slverr = 0;
            if (trnsfr) begin
                if (!seen_tr) begin seen_tr = 1; first_tr_cyc = cyc; end
                if (!latched) begin
                    latched = 1; l_addr = address; l_data = data_in; l_wr = wr; l_dsel = dsel;
                    wait_cnt = $urandom_range(0, max_wait);
                end else if (address !== l_addr || wr !== l_wr || dsel !== l_dsel || data_in !== l_data) begin
                    unstable++;
                end
                if (wait_cnt == 0) begin
                    ready = 1; latched = 0;
                    slverr = (beat_idx == err_beat);
                    if (wr) smem[address] = data_in;
                    else data_out = smem.exists(address) ? smem[address] : dflt(address);
                    b_addr.push_back(address); b_data.push_back(data_in);
                    b_wr.push_back(wr); b_dsel.push_back(dsel);
                    beat_idx++; last_rdy_cyc = cyc;
                end else begin
                    wait_cnt--;
                end
            end else begin
                // stray handshakes outside a beat must be ignored
                ready = ($urandom_range(0, 3) == 0);
                slverr = 1'($urandom_range(0, 1));
                data_out = $urandom;
            end
        end
    end

    task automatic start_cmd(input bit w, input logic [1:0] ds, input logic [31:0] a, input beat_len_t l);
        @(posedge clk); #1;
        beat_idx = 0; widx = 0; fire_pending = 0; seen_tr = 0; gap_cnt = 0; unstable = 0;
        done_cnt = 0; done_err = 0; done_rv = 0;
        b_addr.delete(); b_data.delete(); b_wr.delete(); b_dsel.delete(); rq.delete();
        wen = w;
        cmd_valid = 1; cmd_wr = w; cmd_dsel = ds; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        cmd_valid = 0; cmd_wr = 1'($urandom); cmd_addr = $urandom; cmd_len = 8'($urandom);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin ok = 1; break; end
        end
        wen = 0;
        chk("done_timeout", ok, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_burst(input string nm, input bit w, input logic [1:0] ds,
                               input logic [31:0] a, input beat_len_t l, input int eb);
        int          n_exp;
        bit          e_err;
        logic [31:0] ea, ed;
        logic [31:0] exp_rd[$];
        e_err = (eb >= 0 && eb <= int'(l));
        n_exp = (ABORT && e_err) ? eb + 1 : int'(l) + 1;
        chk({nm, "_beats"}, b_addr.size(), n_exp);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_err"}, done_err, e_err);
        chk({nm, "_stable"}, unstable, 0);
        chk({nm, "_done_lat"}, done_cyc - last_rdy_cyc, 1);
        for (int i = 0; i < n_exp; i++) begin
            ea = a + 32'(i);
            if (w) begin
                ed = wwords[i];
                ref_mem[ea] = ed;
            end else begin
                ed = ref_mem.exists(ea) ? ref_mem[ea] : dflt(ea);
                exp_rd.push_back(ed);
            end
            if (i < b_addr.size()) begin
                chk($sformatf("%s_addr%0d", nm, i), b_addr[i], ea);
                chk($sformatf("%s_wr%0d", nm, i), b_wr[i], w);
                chk($sformatf("%s_dsel%0d", nm, i), b_dsel[i], ds);
                if (w) chk($sformatf("%s_wdata%0d", nm, i), b_data[i], ed);
            end
        end
        if (!w) begin
            chk({nm, "_rcount"}, rq.size(), exp_rd.size());
            chk({nm, "_rv_at_done"}, done_rv, 1'b1);
            for (int i = 0; i < exp_rd.size() && i < rq.size(); i++)
                chk($sformatf("%s_rdata%0d", nm, i), rq[i], exp_rd[i]);
        end
    endtask

    initial begin
        bit          w;
        logic [1:0]  ds;
        logic [31:0] a;
        beat_len_t   l;
        int          eb;
        bit          ok;

        rst_n = 0; cmd_valid = 0; cmd_wr = 0; cmd_dsel = 0; cmd_addr = 0; cmd_len = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {trnsfr, wdata_ready, rdata_valid, done, err, wr, dsel}, 0);
        chk("rst_address", address, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1;

        // single full-word write
        max_wait = 0; err_beat = -1;
        wwords[0] = 32'h000A_3210;
        start_cmd(1, FULLWORD, 32'hF0, 0);
        wait_done();
        check_burst("single_wr", 1, FULLWORD, 32'hF0, 0, -1);
        chk("single_wr_lat", first_tr_cyc - acc_cyc, 2);

        // continuous burst write
        for (int i = 0; i < 64; i++) wwords[i] = 32'hC0D9_42F0 + 32'(i);
        start_cmd(1, HALFWORD, 32'hB0, 7);
        wait_done();
        check_burst("burst_wr", 1, HALFWORD, 32'hB0, 7, -1);
        chk("burst_wr_gap", gap_cnt, 0);

        // burst read of the data just written
        start_cmd(0, BYTE, 32'hB0, 7);
        wait_done();
        check_burst("burst_rd", 0, BYTE, 32'hB0, 7, -1);
        chk("burst_rd_lat", first_tr_cyc - acc_cyc, 1);
        chk("burst_rd_gap", gap_cnt, 0);

        // write data stall after beat 1
        for (int i = 0; i < 64; i++) wwords[i] = 32'h1234_0000 + 32'(i * 3);
        stall_at = 2; stall_left = 4;
        start_cmd(1, FULLWORD, 32'h40, 3);
        wait_done();
        check_burst("stall_wr", 1, FULLWORD, 32'h40, 3, -1);
        chk("stall_gap", gap_cnt, 4);
        stall_at = -1; stall_left = 0;

        // slave error on beat 1
        err_beat = 1;
        start_cmd(0, FULLWORD, 32'h100, 3);
        wait_done();
        check_burst("slverr_rd", 0, FULLWORD, 32'h100, 3, 1);
        for (int i = 0; i < 64; i++) wwords[i] = $urandom;
        start_cmd(1, HALFWORD, 32'h120, 3);
        wait_done();
        check_burst("slverr_wr", 1, HALFWORD, 32'h120, 3, 1);
        err_beat = -1;

        // reset in the middle of beat 3 of 8
        start_cmd(0, FULLWORD, 32'h200, 7);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (beat_idx >= 3 && trnsfr) begin ok = 1; break; end
        end
        chk("mid_rst_reach", ok, 1'b1);
        rst_n = 0;
        #1;
        chk("mid_rst_ctl", {trnsfr, wdata_ready, rdata_valid, done, err, wr, dsel}, 0);
        chk("mid_rst_address", address, 0);
        chk("mid_rst_data_in", data_in, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        start_cmd(0, FULLWORD, 32'h300, 0);
        wait_done();
        check_burst("post_rst_rd", 0, FULLWORD, 32'h300, 0, -1);

        // randomized bursts
        max_wait = 2;
        for (int n = 0; n < 14; n++) begin
            w  = 1'($urandom_range(0, 1));
            ds = 2'($urandom_range(0, 3));
            l  = beat_len_t'($urandom_range(0, 12));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : 32'($urandom_range(0, 63));
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(l))) : -1;
            for (int i = 0; i < 64; i++) wwords[i] = $urandom;
            err_beat   = eb;
            stall_at   = int'($urandom_range(0, int'(l)));
            stall_left = int'($urandom_range(0, 5));
            start_cmd(w, ds, a, l);
            wait_done();
            check_burst($sformatf("rnd%0d", n), w, ds, a, l, eb);
            if (!w) chk($sformatf("rnd%0d_rd_lat", n), first_tr_cyc - acc_cyc, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
